// File: rtl/matrix_ram_pkg.sv
// matrix_ram_pkg: shared scan/engine enums and a width helper for matrix_burst_ram
package matrix_ram_pkg;
  typedef enum logic {SCAN_ROW, SCAN_COL} scan_mode_e;
  typedef enum logic {IDLE, RUN} engine_state_e;
  function automatic int max_width(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rect_sync_ram.sv
// rect_sync_ram: storage array; write port (wr_en/wr_addr/wr_data), enabled registered read port (rd_en/rd_addr/rd_data), write-first forwarding under MATRIX_RAM_BYPASS_EN
module rect_sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clock)
    if (!reset_n) rd_data <= '0;
    else if (rd_en)
`ifdef MATRIX_RAM_BYPASS_EN
      rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
`else
      rd_data <= mem[rd_addr];
`endif
endmodule

// File: rtl/matrix_burst_ram.sv
// matrix_burst_ram: 2-D RAM with row/column burst read engine; ports: clock/reset_n, write (wr_*), request (req_*), stream (out_*); option MATRIX_RAM_BYPASS_EN
module matrix_burst_ram
  import matrix_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ROW_ADDR_WIDTH = 6,
  parameter int COL_ADDR_WIDTH = 6,
  localparam int LEN_WIDTH     = max_width(ROW_ADDR_WIDTH, COL_ADDR_WIDTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ROW_ADDR_WIDTH-1:0] wr_row,
  input  logic [COL_ADDR_WIDTH-1:0] wr_col,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_mode,
  input  logic [ROW_ADDR_WIDTH-1:0] req_row,
  input  logic [COL_ADDR_WIDTH-1:0] req_col,
  input  logic [LEN_WIDTH-1:0]      req_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_last
);
  localparam logic [LEN_WIDTH-1:0] ROW_LEN = LEN_WIDTH'(2**COL_ADDR_WIDTH);
  localparam logic [LEN_WIDTH-1:0] COL_LEN = LEN_WIDTH'(2**ROW_ADDR_WIDTH);
  engine_state_e             state;
  scan_mode_e                mode;
  logic [ROW_ADDR_WIDTH-1:0] row;
  logic [COL_ADDR_WIDTH-1:0] col;
  logic [LEN_WIDTH-1:0]      remaining;
  logic                      rd_en;
  assign rd_en = state == RUN && remaining != '0 && (!out_valid || out_ready);
  always_ff @(posedge clock)
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mode      <= SCAN_ROW;
      row       <= '0;
      col       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (req_valid && req_ready) begin
          state     <= RUN;
          req_ready <= 1'b0;
          mode      <= scan_mode_e'(req_mode);
          row       <= req_row;
          col       <= req_col;
          remaining <= req_count != '0 ? req_count : req_mode ? COL_LEN : ROW_LEN;
        end
      end else if (rd_en) begin
        remaining <= remaining - 1'b1;
        if (mode == SCAN_ROW) col <= col + 1'b1;
        else row <= row + 1'b1;
        if (remaining == LEN_WIDTH'(1)) begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      end
      if (rd_en) begin
        out_valid <= 1'b1;
        out_last  <= remaining == LEN_WIDTH'(1);
      end else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  rect_sync_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ROW_ADDR_WIDTH + COL_ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_addr({wr_row, wr_col}),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr({row, col}),
    .rd_data(out_data)
  );
endmodule

// File: tb/tb_matrix_burst_ram.sv
// tb_matrix_burst_ram: directed and randomized burst checks of a 4x4 matrix_burst_ram against a behavioural matrix model
module tb_matrix_burst_ram;
  logic       clock, reset_n, wr_en, req_valid, req_ready, req_mode, out_valid, out_ready, out_last;
  logic [1:0] wr_row, wr_col, req_row, req_col;
  logic [7:0] wr_data, out_data;
  logic [2:0] req_count;
  logic [7:0] mdl [16];
  int tests = 0, fails = 0;

  matrix_burst_ram #(.DATA_WIDTH(8), .ROW_ADDR_WIDTH(2), .COL_ADDR_WIDTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_row(req_row), .req_col(req_col), .req_count(req_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d);
    @(negedge clock);
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    mdl[r*4+c] = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // rmode: 0 = out_ready always high, 1 = alternating, 2 = random
  task automatic burst(input bit m, input int r, input int c, input int cnt, input int rmode, input bit wr00);
    logic [7:0] exq[$];
    logic [7:0] pd;
    logic       pl;
    bit         hold;
    int         n, got, k, last_k;
    n = cnt == 0 ? 4 : cnt;
    for (int i = 0; i < n; i++)
      exq.push_back(m ? mdl[((r + i) % 4) * 4 + c] : mdl[r * 4 + (c + i) % 4]);
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_mode = m; req_row = 2'(r); req_col = 2'(c); req_count = 3'(cnt); out_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    chk("accept_state", {req_ready, out_valid}, 0);
    if (wr00) begin
      wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hAA;
      mdl[0] = 8'hAA;
`ifdef MATRIX_RAM_BYPASS_EN
      exq[0] = 8'hAA;
`endif
    end
    got = 0; k = 1; hold = 0; last_k = 0; pd = '0; pl = 1'b0;
    while (got < n && k < 200) begin
      @(negedge clock);
      k++;
      wr_en = 1'b0;
      if (hold) chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(k % 2) : 1'($urandom_range(0, 9) < 7);
      hold = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      if (out_valid && out_ready) begin
        chk("data", out_data, exq[got]);
        chk("last", out_last, got == n - 1);
        got++;
        last_k = k;
      end
    end
    chk("burst_complete", got, n);
    if (rmode == 0) chk("consecutive", last_k, n + 1);
    @(negedge clock);
    chk("drained", {out_valid, req_ready}, 2'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    int got, k;
    reset_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    req_valid = 1'b0; req_mode = 1'b0; req_row = '0; req_col = '0; req_count = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {req_ready, out_valid, out_last, out_data}, {3'b100, 8'h00});
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(r, c, 8'(4 * r + c));
    burst(1'b0, 1, 2, 4, 0, 1'b0);
    burst(1'b1, 3, 1, 0, 0, 1'b0);
    burst(1'b0, 0, 0, 4, 1, 1'b0);
    burst(1'b0, 0, 0, 4, 0, 1'b1);
    burst(1'b0, 0, 0, 1, 0, 1'b0);
    @(negedge clock);
    req_valid = 1'b1; req_mode = 1'b0; req_row = 2'd2; req_col = 2'd0; req_count = 3'd4; out_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    got = 0; k = 0;
    while (got < 2 && k < 20) begin
      @(negedge clock);
      k++;
      if (out_valid) begin
        chk("rst_mid_data", out_data, mdl[8 + got]);
        got++;
      end
    end
    chk("rst_mid_pre", got, 2);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_after", {out_valid, req_ready}, 2'b01);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("rst_mid_quiet", out_valid, 0);
    end
    out_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      repeat (3) wr($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
      burst(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), 2, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
